// File: rtl/dmem_if.sv
// Data memory request/response bundle between the MEM stage (master) and the
// data memory responder (slave).
//   mem_read / mem_write  : request strobes, held until mem_resp
//   mem_byte_enable       : store byte lanes
//   mem_address           : byte address
//   mem_wdata             : lane-aligned store data
//   mem_rdata             : load data, valid with mem_resp
//   mem_resp              : one-cycle completion pulse
//   mem_error             : misaligned-access flag (alignment-check builds only)
interface dmem_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              mem_read;
  logic              mem_write;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              mem_error;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder for the MEM stage: single-ported word array with
// byte-enable writes and a fixed response latency of LATENCY cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_if.slave (request in, mem_rdata/mem_resp/mem_error out)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   LATENCY     : cycles from request acceptance to mem_resp (>= 1)
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   Defined   : misaligned accesses raise mem_error with mem_resp and
//               misaligned writes are dropped.
//   Undefined : mem_error is tied low.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CW     = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Captured request
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              write_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]        lo_q;
  logic              error_q;
`endif

  logic [DATA_W-1:0] rdata_q;
  logic              resp_q;

  logic              accept_c;
  logic              enter_resp_c;
  logic              do_write_c;
  logic              do_read_c;
  logic              misaligned_c;

  // Effective access operands: live inputs when RESP is entered straight
  // from IDLE (LATENCY == 1), captured copies otherwise.
  logic [AW-1:0]     acc_idx_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic [BE_W-1:0]   acc_be_c;
  logic              acc_write_c;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]        acc_lo_c;
`endif

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_c     = 1'b0;
    enter_resp_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          accept_c = 1'b1;
          cnt_d    = CNT_LOAD;
          if (CNT_LOAD == '0) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access operand selection
  always_comb begin
    acc_idx_c   = idx_q;
    acc_wdata_c = wdata_q;
    acc_be_c    = be_q;
    acc_write_c = write_q;
`ifdef DMEM_ALIGN_CHECK_EN
    acc_lo_c    = lo_q;
`endif
    if (state_q == IDLE) begin
      acc_idx_c   = bus.mem_address[AW+1:2];
      acc_wdata_c = bus.mem_wdata;
      acc_be_c    = bus.mem_byte_enable;
      acc_write_c = bus.mem_write;
`ifdef DMEM_ALIGN_CHECK_EN
      acc_lo_c    = bus.mem_address[1:0];
`endif
    end
  end

  // Alignment check: halfwords need even addresses, full words need
  // word-aligned addresses; other lane patterns are not checked.
`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned_c = 1'b0;
    if ((acc_be_c == 4'b0011 || acc_be_c == 4'b1100) && acc_lo_c[0]) begin
      misaligned_c = 1'b1;
    end
    if (acc_be_c == 4'b1111 && acc_lo_c != 2'b00) begin
      misaligned_c = 1'b1;
    end
  end
`else
  assign misaligned_c = 1'b0;
`endif

  // Write wins when both strobes are high, so a read only fires for pure loads
  assign do_write_c = enter_resp_c && acc_write_c && !misaligned_c;
  assign do_read_c  = enter_resp_c && !acc_write_c;

  // State, capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      lo_q    <= 2'b00;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= enter_resp_c;
      if (accept_c) begin
        idx_q   <= bus.mem_address[AW+1:2];
        wdata_q <= bus.mem_wdata;
        be_q    <= bus.mem_byte_enable;
        write_q <= bus.mem_write;
`ifdef DMEM_ALIGN_CHECK_EN
        lo_q    <= bus.mem_address[1:0];
`endif
      end
      if (do_read_c) begin
        rdata_q <= mem[acc_idx_c];
      end
`ifdef DMEM_ALIGN_CHECK_EN
      error_q <= enter_resp_c && misaligned_c;
`endif
    end
  end

  // Array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write_c) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (acc_be_c[i]) begin
          mem[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.mem_error = error_q;
`else
  assign bus.mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=3).
module tb_dmem_responder;

  localparam int unsigned LAT = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, wait (bounded) for mem_resp, then drop the request.
  // lat is the cycle of mem_resp counted from the request cycle, -1 on timeout.
  task automatic transact(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int lat, output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    bus.mem_write       = wr;
    bus.mem_read        = rd;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        lat   = c;
        rdata = bus.mem_rdata;
        err   = bus.mem_error;
        break;
      end
    end
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata = '0;
    bus.mem_byte_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want %h", bus.mem_rdata, 32'h0); end
    checks++;
    if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", bus.mem_resp); end
    checks++;
    if (bus.mem_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.mem_error); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, er);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL full_wr_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL full_wr_error got %b want 0", er); end
    transact(1'b0, 1'b1, 32'h10, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL full_rd_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd_data got %h want %h", rd, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b0, 32'h20, 32'h11223344, 4'b1111, lat, rd, er);
    transact(1'b1, 1'b0, 32'h20, 32'h0000AA00, 4'b0010, lat, rd, er);
    transact(1'b0, 1'b1, 32'h20, 32'h0, 4'b0001, lat, rd, er);
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane_data got %h want %h", rd, 32'h1122AA44); end
    // Empty byte-enable still completes but leaves the word alone
    transact(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL be0_latency got %0d want %0d", lat, LAT); end
    transact(1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, lat, rd, er);
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL be0_data got %h want %h", rd, 32'h1122AA44); end
    transact(1'b1, 1'b0, 32'h20, 32'h77000000, 4'b1000, lat, rd, er);
    transact(1'b0, 1'b1, 32'h20, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h7722AA44) begin errors++; $display("FAIL byte3_data got %h want %h", rd, 32'h7722AA44); end
  endtask

  task automatic test_latency_hold();
    logic exp;
    @(posedge clk); #1;
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h10;
    bus.mem_byte_enable = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = (c == 3 || c == 7);
      checks++;
      if (bus.mem_resp !== exp) begin errors++; $display("FAIL latency_resp_c%0d got %b want %b", c, bus.mem_resp, exp); end
      if (c == 4) begin
        checks++;
        if (bus.mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h want %h", bus.mem_rdata, 32'hDEADBEEF); end
      end
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b0, 32'h400, 32'h55AA55AA, 4'b1111, lat, rd, er);
    transact(1'b0, 1'b1, 32'h000, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL alias_data got %h want %h", rd, 32'h55AA55AA); end
    transact(1'b0, 1'b1, 32'h003, 32'h0, 4'b0001, lat, rd, er);
    checks++;
    if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL low_bits_data got %h want %h", rd, 32'h55AA55AA); end
  endtask

  task automatic test_both_strobes();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b1, 32'h10, 32'h12345678, 4'b1111, lat, rd, er);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL both_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL both_rdata_hold got %h want %h", rd, 32'h55AA55AA); end
    transact(1'b0, 1'b1, 32'h10, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL both_written got %h want %h", rd, 32'h12345678); end
  endtask

  task automatic test_input_change();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b0, 32'h54, 32'h01020304, 4'b1111, lat, rd, er);
    @(posedge clk); #1;
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h50;
    bus.mem_wdata = 32'hA5A5A5A5;
    bus.mem_byte_enable = 4'b1111;
    @(posedge clk); #1;
    bus.mem_address = 32'h54;
    bus.mem_wdata = 32'h5A5A5A5A;
    bus.mem_byte_enable = 4'b0000;
    for (int c = 0; c < 10 && bus.mem_resp !== 1'b1; c++) @(negedge clk);
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    transact(1'b0, 1'b1, 32'h50, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL capture_addr0 got %h want %h", rd, 32'hA5A5A5A5); end
    transact(1'b0, 1'b1, 32'h54, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h01020304) begin errors++; $display("FAIL capture_addr1 got %h want %h", rd, 32'h01020304); end
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [31:0] rd; logic er; logic seen;
    transact(1'b1, 1'b0, 32'h30, 32'h00000000, 4'b1111, lat, rd, er);
    @(posedge clk); #1;
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h30;
    bus.mem_wdata = 32'hFFFFFFFF;
    bus.mem_byte_enable = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    #2;
    checks++;
    if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h want %h", bus.mem_rdata, 32'h0); end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_resp !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_resp got %b want 0", seen); end
    transact(1'b0, 1'b1, 32'h30, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h00000000) begin errors++; $display("FAIL midrst_array got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_align();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, 1'b0, 32'h40, 32'h11111111, 4'b1111, lat, rd, er);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL align_ok_error got %b want 0", er); end
    transact(1'b1, 1'b0, 32'h42, 32'h22222222, 4'b1111, lat, rd, er);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL align_latency got %0d want %0d", lat, LAT); end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL align_mis_error got %b want 1", er); end
    transact(1'b0, 1'b1, 32'h40, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL align_suppress got %h want %h", rd, 32'h11111111); end
    transact(1'b0, 1'b1, 32'h41, 32'h0, 4'b0011, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL align_rd_error got %b want 1", er); end
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL align_rd_data got %h want %h", rd, 32'h11111111); end
`else
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL noalign_error got %b want 0", er); end
    transact(1'b0, 1'b1, 32'h40, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h22222222) begin errors++; $display("FAIL noalign_data got %h want %h", rd, 32'h22222222); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_latency_hold();
    test_alias();
    test_both_strobes();
    test_input_change();
    test_reset_mid_busy();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the MEM-stage data memory interface: accepts read/write requests from the memory stage and returns load data and a completion pulse.
- The returned load data is what the MEM/WB latch captures as MDR.
- Single-ported, word-organised synchronous array with byte-enable writes and a programmable fixed response latency.
- Used in simulation and as the on-chip data scratchpad when no cache is present.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance to mem_resp; integer, >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  input  1  load request; held until mem_resp is seen.
- mem_write  input  1  store request; held until mem_resp is seen.
- mem_byte_enable  input  4  store byte lanes; bit i selects bits [8i+7:8i].
- mem_address  input  32  byte address.
- mem_wdata  input  32  store data, already lane-aligned by the requester.
- mem_rdata  output  32  load data; valid while mem_resp=1.
- mem_resp  output  1  one-cycle completion pulse.
- mem_error  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset values: mem_rdata=0, mem_resp=0, mem_error=0, latency counter=0, captured request registers=0. Array contents are not reset.
- IDLE with mem_read or mem_write high:
  - Capture the address, wdata, byte_enable and op in the same cycle.
  - Load the counter with LATENCY-1.
  - Go to RESP if the counter value is 0, otherwise go to BUSY.
- mem_read and mem_write both high: treated as a write; no read data is produced and mem_rdata holds its previous value.
- BUSY: decrement the counter each cycle; when it reaches 0, go to RESP.
- The array access happens on the edge that enters RESP, using only the captured values. Input changes after acceptance are ignored.
- RESP: mem_resp=1 for exactly one cycle, then return to IDLE. Any request present during RESP is ignored.
- Latency: a request first high in cycle 0 gets mem_resp high in cycle LATENCY. The next request is accepted no earlier than cycle LATENCY+1.
- Back-to-back: the requester drops mem_read/mem_write in the cycle after mem_resp. If it keeps them high, IDLE treats that as a new request.
- Addressing: word index = mem_address[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so accesses alias modulo DEPTH_WORDS*4 bytes.
  - Bits [1:0] are ignored for data purposes.
- Write: only lanes with mem_byte_enable[i]=1 are updated. byte_enable=4'b0000 completes normally with no array change.
- Read: always returns the full 32-bit word, regardless of byte_enable. mem_rdata is registered, updated only on a read completion, and holds its value between completions.
- Reset mid-operation (BUSY or RESP): state goes to IDLE immediately and outputs take their reset values.
  - A write still in BUSY is not performed.
  - A write that already entered RESP has been performed.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: in RESP, mem_error=1 (coincident with mem_resp) when the captured access is misaligned:
  - byte_enable in {4'b0011, 4'b1100} with address[0]=1; or
  - byte_enable=4'b1111 with address[1:0]!=0.
  - A misaligned write is suppressed (array unchanged). A misaligned read still returns the word.
- Not defined: mem_error is tied to 0 and no alignment logic is generated.

Test Plan:
- Full-word store then load: write 0xDEADBEEF to 0x10 (be=4'b1111), read 0x10 -> mem_rdata=0xDEADBEEF with mem_resp.
- Byte store: preload 0x11223344 at 0x20, write 0x0000AA00 with be=4'b0010, read back -> 0x1122AA44.
- Latency check, LATENCY=3: mem_read asserted in cycle 0 -> mem_resp=1 only in cycle 3, 0 in cycles 0-2 and 4; read held through cycle 3 -> re-accepted in cycle 4, next mem_resp in cycle 7.
- Aliasing, DEPTH_WORDS=256: write 0x55AA55AA to 0x400, read 0x000 -> 0x55AA55AA.
- Reset mid-BUSY, LATENCY=4: write 0xFFFFFFFF to 0x30 over prior 0x0, pulse rst_n low in cycle 2 -> mem_resp never asserted; later read of 0x30 -> 0x00000000.
- DMEM_ALIGN_CHECK_EN defined: write be=4'b1111 at 0x42 -> mem_resp=1 with mem_error=1, and the word at 0x40 is unchanged.
